muldiv_ex: RTL and testbench
============================

# muldiv_ex

Iterative multiply/divide unit in the execute stage, directly downstream of the fetch stage. It consumes the instruction register fetch delivers (`instruction_EX`) and the two register operands, and runs MIPS MULT/MULTU/DIV/DIVU over `WIDTH` cycles into private HI/LO registers. It serves MFHI/MFLO/MTHI/MTLO and drives the `stall_EX` that fetch uses to hold the current instruction while a HI/LO hazard is pending.

## Interface
- `WIDTH`, default 32: operand width; also the iteration count of one operation.
- `clk`  in  1: clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `instruction_EX`  in  32: instruction currently in EX (from fetch).
- `rs_data`  in  WIDTH: rs operand (dividend / multiplicand / MTHI-MTLO source).
- `rt_data`  in  WIDTH: rt operand (divisor / multiplier).
- `stall_EX`  out  1: hold fetch/EX this cycle; combinational.
- `busy`  out  1: operation in flight; registered.
- `mf_valid`  out  1: `instruction_EX` is MFHI/MFLO and not stalled; combinational.
- `mf_data`  out  WIDTH: HI (MFHI) or LO (MFLO); 0 when `mf_valid`=0.
- `hi`, `lo`  out  WIDTH each: architectural HI/LO, registered.

## Operation
- Decode applies only when opcode `[31:26]`=0. Funct `[5:0]` values:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU: the muldiv group.
  - 0x10 MFHI, 0x12 MFLO: reads.
  - 0x11 MTHI, 0x13 MTLO: writes.
  - Any other instruction is ignored.
- States: IDLE (`busy`=0) and RUN (`busy`=1, counter 0..WIDTH-1).
- `stall_EX`=1 exactly when `busy`=1 and `instruction_EX` is in the muldiv group, MF*, or MT*. Otherwise `stall_EX`=0.
- Issue happens in IDLE when a muldiv-group instruction is in EX:
  - Capture operand magnitudes (signed ops take absolute values) and result-sign flags.
  - Clear the counter and go to RUN.
  - `stall_EX` stays 0 in the issue cycle, so the instruction retires from EX immediately.
- RUN performs one iteration per edge:
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient builds in the low half, remainder in the high half.
- Completion happens on the edge after iteration WIDTH-1:
  - Sign-correct the result.
  - Multiply writes HI:LO = 2·WIDTH product.
  - Divide writes LO = quotient (truncated toward zero) and HI = remainder (sign of dividend).
  - Return to IDLE.
- Divide by zero is detected at issue:
  - Full latency still runs.
  - Result is HI = original `rs_data`, LO = all ones, for both signed and unsigned.
- Signed overflow (−2^(W−1) / −1): LO = 0x80000000, HI = 0 (two's-complement wrap).
- MTHI/MTLO in IDLE: HI/LO take `rs_data` at the edge; no stall.
- MFHI/MFLO in IDLE: `mf_data` returns the current register value combinationally.
- Unrelated instructions pass freely while RUN proceeds; nothing stalls them.

## Timing
- Reset values: `busy`=0, counter=0, `hi`=`lo`=0, accumulator=0.
  - Combinational outputs then give `stall_EX`=0; `mf_valid` and `mf_data` follow `instruction_EX` with the reset HI/LO.
- Latency: issue at edge E0; `busy`=1 from E0 until E_WIDTH; HI/LO update and `busy` drops at edge E_WIDTH (32 cycles for WIDTH=32).
- Dependent instruction in EX during RUN:
  - `stall_EX` is high until E_WIDTH.
  - In the following cycle it sees the new HI/LO. For a muldiv, that cycle is its issue cycle (back-to-back, no extra bubble).
- Reset in RUN: the operation is abandoned, HI/LO are cleared, and `stall_EX` is 0 in the cycle after the reset edge.
- MT* instructions cannot reach EX unstalled during RUN, so a simultaneous MT* write and completion write cannot occur.

## Structure
- `muldiv_pkg` holds:
  - funct constants: FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO;
  - the opcode constant OP_RTYPE;
  - the state enum `muldiv_state_t` {IDLE, RUN};
  - the operation enum {OP_MUL, OP_DIV}.
- Sub-module `muldiv_iter` contains the accumulator, counter and one-step shift-add / shift-subtract datapath.
- The top level keeps decode, the stall logic, sign handling and HI/LO.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3):
  - `busy` high for exactly 32 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Divides:
  - DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 2 → LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO in EX one cycle after MULT 5 × 6:
  - `stall_EX`=1 for 32 cycles, `mf_valid`=0 throughout.
  - Next cycle: `mf_valid`=1, `mf_data`=30.
  - An unrelated instruction (ADDU) placed instead of MFLO never stalls.
- DIV 5 / 0 → after 32 cycles HI=5, LO=0xFFFFFFFF. A second DIV held behind it issues on the cycle right after completion.
- Reset mid-run:
  - Assert `rst` 10 cycles into DIVU 100 / 3.
  - Next cycle: `busy`=0, `hi`=`lo`=0, `stall_EX`=0.
  - MTHI 0x1234 then MFHI returns 0x1234.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared decode constants and state/operation types for the execute-stage
// multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic {IDLE, RUN} muldiv_state_t;
  typedef enum logic {OP_MUL, OP_DIV} muldiv_op_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iteration engine: 2*WIDTH accumulator, iteration counter and the one-step
// shift-add (multiply) / restoring shift-subtract (divide) datapath.
// Operates on unsigned magnitudes only; signs are handled by the caller.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run,
  input  muldiv_op_t           op,
  input  logic [WIDTH-1:0]     init_lo,
  input  logic [WIDTH-1:0]     opnd_in,
  output logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign last = run && (cnt == CW'(WIDTH - 1));

  // One iteration step. The partial remainder stays below the divisor, so
  // after the shift it is below 2*divisor and bit WIDTH of the difference
  // is a clean borrow flag.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = rem_sh - {1'b0, opnd};
    acc_next = acc;
    if (op == OP_MUL)
      acc_next = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Load on issue, then step once per cycle while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (start) begin
      acc  <= {{WIDTH{1'b0}}, init_lo};
      opnd <= opnd_in;
      cnt  <= '0;
    end else if (run) begin
      acc  <= acc_next;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_ex.sv
// Execute-stage MIPS MULT/MULTU/DIV/DIVU unit with private HI/LO.
// Decodes the EX instruction, raises stall_EX on HI/LO hazards while an
// operation runs, and applies sign correction on completion.
module muldiv_ex
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction_EX,
  input  logic [WIDTH-1:0]  rs_data,
  input  logic [WIDTH-1:0]  rt_data,
  output logic              stall_EX,
  output logic              busy,
  output logic              mf_valid,
  output logic [WIDTH-1:0]  mf_data,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  muldiv_state_t state;
  muldiv_op_t    op_q, md_op;

  logic [5:0] funct;
  logic       is_rtype, is_md, is_mf, is_mt, issue, sgn;
  logic       rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag, init_lo, opnd_in;

  logic             neg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] rs_q;

  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               last;

  assign funct    = instruction_EX[5:0];
  assign is_rtype = (instruction_EX[31:26] == OP_RTYPE);
  assign is_md    = is_rtype && (funct == FN_MULT || funct == FN_MULTU ||
                                 funct == FN_DIV  || funct == FN_DIVU);
  assign is_mf    = is_rtype && (funct == FN_MFHI || funct == FN_MFLO);
  assign is_mt    = is_rtype && (funct == FN_MTHI || funct == FN_MTLO);

  assign stall_EX = busy && (is_md || is_mf || is_mt);
  assign mf_valid = is_mf && !stall_EX;
  assign mf_data  = !mf_valid ? '0 : (funct == FN_MFHI) ? hi : lo;

  // Odd funct codes in the muldiv group are the unsigned variants.
  assign sgn    = !funct[0];
  assign md_op  = funct[1] ? OP_DIV : OP_MUL;
  assign issue  = (state == IDLE) && is_md;
  assign rs_neg = sgn && rs_data[WIDTH-1];
  assign rt_neg = sgn && rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // Multiply shifts the multiplier (rt) out of the low half; divide shifts
  // the dividend (rs) up into the remainder.
  assign init_lo = (md_op == OP_MUL) ? rt_mag : rs_mag;
  assign opnd_in = (md_op == OP_MUL) ? rs_mag : rt_mag;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (issue),
    .run      (busy),
    .op       (op_q),
    .init_lo  (init_lo),
    .opnd_in  (opnd_in),
    .acc      (acc),
    .acc_next (acc_next),
    .last     (last)
  );

  // Sign correction of the final iteration's result.
  always_comb begin
    prod = neg_q  ? -acc_next : acc_next;
    quot = neg_q  ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = rneg_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
  end

  // Issue/run/complete FSM owning HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      rs_q   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state  <= RUN;
            busy   <= 1'b1;
            op_q   <= md_op;
            neg_q  <= rs_neg ^ rt_neg;
            rneg_q <= rs_neg;
            dz_q   <= (md_op == OP_DIV) && (rt_data == '0);
            rs_q   <= rs_data;
          end else if (is_mt) begin
            if (funct == FN_MTHI) hi <= rs_data;
            else                  lo <= rs_data;
          end
        end
        RUN: begin
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (op_q == OP_MUL) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (dz_q) begin
              hi <= rs_q;
              lo <= '1;
            end else begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ex.sv
// Scoreboard bench for muldiv_ex (WIDTH=32): expected HI:LO pushed at issue,
// popped and compared when busy falls.
module tb_muldiv_ex;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADDU = 6'h21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_EX = '0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        stall_EX, busy, mf_valid;
  logic [31:0] mf_data, hi, lo;

  int errs = 0, checks = 0;
  logic [63:0] sb[$];
  logic prev_busy = 1'b0;

  muldiv_ex #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instruction_EX(instruction_EX),
    .rs_data(rs_data), .rt_data(rt_data), .stall_EX(stall_EX), .busy(busy),
    .mf_valid(mf_valid), .mf_data(mf_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] fn);
    return {26'd0, fn};
  endfunction

  // Reference HI:LO for one muldiv instruction.
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb_, q, r;
    sa = a; sb_ = b;
    case (fn)
      F_MULT:  begin sp = 64'(sa) * 64'(sb_); return sp; end
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb_; r = sa % sb_;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Completion monitor; a busy drop caused by reset carries no result.
  always @(negedge clk) begin
    if (prev_busy && !busy && !rst) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("hilo", {hi, lo}, sb.pop_front());
    end
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, output int n);
    instruction_EX = mk(fn); rs_data = a; rt_data = b;
    sb.push_back(exp);
    step();
    instruction_EX = '0;
    wait_idle(n);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [5:0]  fns[4];
    fns[0] = F_MULT; fns[1] = F_MULTU; fns[2] = F_DIV; fns[3] = F_DIVU;

    // Reset state.
    instruction_EX = mk(F_MFHI);
    step(); step();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall_EX), 64'd0);
    chk("rst_mfv", 64'(mf_valid), 64'd1);
    chk("rst_mfd", 64'(mf_data), 64'd0);
    step(); rst = 1'b0; instruction_EX = '0;

    // Directed arithmetic cases.
    run_op(F_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, n);
    chk("mult_latency", 64'(n), 64'd32);
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, n);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, n);
    run_op(F_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, n);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, n);

    // MFLO held behind MULT 5x6.
    instruction_EX = mk(F_MULT); rs_data = 32'd5; rt_data = 32'd6;
    sb.push_back(64'd30);
    step();
    instruction_EX = mk(F_MFLO);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mf_stall", 64'(stall_EX), 64'd1);
      chk("mf_hold_valid", 64'(mf_valid), 64'd0);
    end
    @(negedge clk);
    chk("mf_release", 64'(stall_EX), 64'd0);
    chk("mf_valid", 64'(mf_valid), 64'd1);
    chk("mf_data", 64'(mf_data), 64'd30);
    step(); instruction_EX = '0;

    // Unrelated instruction never stalls.
    instruction_EX = mk(F_MULTU); rs_data = 32'd9; rt_data = 32'd9;
    sb.push_back(64'd81);
    step();
    instruction_EX = mk(F_ADDU);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("addu_nostall", 64'(stall_EX), 64'd0);
    end
    wait_idle(n);
    instruction_EX = '0;

    // Divide by zero with a DIV queued behind it.
    instruction_EX = mk(F_DIV); rs_data = 32'd5; rt_data = 32'd0;
    sb.push_back(64'h0000_0005_FFFF_FFFF);
    step();
    rs_data = 32'd100; rt_data = 32'd7;
    sb.push_back(model(F_DIV, 32'd100, 32'd7));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("dz_stall", 64'(stall_EX), 64'd1);
    end
    @(negedge clk);
    chk("b2b_gap_stall", 64'(stall_EX), 64'd0);
    chk("b2b_gap_busy", 64'(busy), 64'd0);
    step();
    instruction_EX = '0;
    @(negedge clk);
    chk("b2b_issue", 64'(busy), 64'd1);
    wait_idle(n);

    // Random operands through the model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = (i == 5) ? 32'd0 : $urandom;
      if (i[0]) rb = rb >> $urandom_range(31, 0);
      run_op(fns[i % 4], ra, rb, model(fns[i % 4], ra, rb), n);
    end

    // Reset in the middle of DIVU 100/3.
    instruction_EX = mk(F_DIVU); rs_data = 32'd100; rt_data = 32'd3;
    step();
    instruction_EX = mk(F_MFLO);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_hi", 64'(hi), 64'd0);
    chk("rr_lo", 64'(lo), 64'd0);
    chk("rr_stall", 64'(stall_EX), 64'd0);
    instruction_EX = '0;
    step(); rst = 1'b0;
    instruction_EX = mk(F_MTHI); rs_data = 32'h1234;
    step();
    instruction_EX = mk(F_MFHI); rs_data = '0;
    @(negedge clk);
    chk("mthi_valid", 64'(mf_valid), 64'd1);
    chk("mthi_mfhi", 64'(mf_data), 64'h1234);
    step(); instruction_EX = '0;

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
